elock_ctrl: RTL and testbench

Synchronous, parametrised keypad door-lock controller; successor to the current edge-triggered lock FSM. Accepts one-cycle key events from the keypad scanner, assembles a CODE_LEN-digit entry, and runs the unarmed/locked/open/fail/alarm sequence with a configurable fail limit, a timed fail indication, a two-step alarm clear and in-field code change. Sits between the keypad scanner and the panel LEDs / door sensor.

---
 rtl/elock_pkg.sv | 45 ++++
 rtl/elock_entry.sv | 44 ++++
 rtl/elock_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_elock_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elock_pkg.sv
// Shared types and constants for the keypad door-lock controller.
// Light patterns are {alarm, locked, armed, fail, open}.
package elock_pkg;

    typedef enum logic [2:0] {
        ST_UNARMED,
        ST_LOCKED,
        ST_OPEN,
        ST_FAIL,
        ST_ALARM,
        ST_ALARM_FAIL,
        ST_PCHANGE
    } state_t;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    localparam logic [4:0] LIGHTS_UNARMED    = 5'b00000;
    localparam logic [4:0] LIGHTS_LOCKED     = 5'b01100;
    localparam logic [4:0] LIGHTS_OPEN       = 5'b00101;
    localparam logic [4:0] LIGHTS_FAIL       = 5'b01110;
    localparam logic [4:0] LIGHTS_ALARM      = 5'b11100;
    localparam logic [4:0] LIGHTS_ALARM_FAIL = 5'b11110;
    localparam logic [4:0] LIGHTS_PCHANGE    = 5'b00111;

    function automatic logic [4:0] lights_of(input state_t s);
        logic [4:0] l;
        case (s)
            ST_UNARMED:    l = LIGHTS_UNARMED;
            ST_LOCKED:     l = LIGHTS_LOCKED;
            ST_OPEN:       l = LIGHTS_OPEN;
            ST_FAIL:       l = LIGHTS_FAIL;
            ST_ALARM:      l = LIGHTS_ALARM;
            ST_ALARM_FAIL: l = LIGHTS_ALARM_FAIL;
            ST_PCHANGE:    l = LIGHTS_PCHANGE;
            default:       l = LIGHTS_UNARMED;
        endcase
        return l;
    endfunction

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/elock_entry.sv
// Digit entry buffer: shifts digits in at the LSB nibble and flags a full entry
// for one compare cycle, after which the buffer empties itself.
module elock_entry #(
    parameter int CODE_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  digit_valid,
    input  logic [3:0]            digit,
    input  logic                  clear,
    output logic [4*CODE_LEN-1:0] code,
    output logic [3:0]            entry_cnt,
    output logic                  full
);

    localparam int W = 4 * CODE_LEN;

    logic [W-1:0] shreg;
    logic [3:0]   cnt;

    assign full      = (cnt == 4'(CODE_LEN));
    assign code      = shreg;
    assign entry_cnt = cnt;

    // A digit landing in the compare (or clear) cycle starts a fresh entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (digit_valid) begin
            if (full || clear) begin
                shreg <= W'(digit);
                cnt   <= 4'd1;
            end else begin
                shreg <= W'({shreg, digit});
                cnt   <= cnt + 4'd1;
            end
        end else if (full || clear) begin
            shreg <= '0;
            cnt   <= '0;
        end
    end

endmodule

// File: rtl/elock_ctrl.sv
// Keypad door-lock controller: sequencing FSM, user code, fail counter,
// two-step alarm clear and fail-indication timer around the entry buffer.
//
// state         | meaning
// UNARMED       | idle, waiting for '#'
// LOCKED        | armed, accepting codes
// OPEN          | unlocked, door may open; master code enters PCHANGE
// FAIL          | wrong code indication, timed, keys dropped
// ALARM         | fail limit reached, needs user then master code
// ALARM_FAIL    | wrong code during alarm, timed, keys dropped
// PCHANGE       | next full entry becomes the user code
module elock_ctrl
    import elock_pkg::*;
#(
    parameter int                    CODE_LEN     = 4,
    parameter int                    MAX_FAIL     = 2,
    parameter int                    FAIL_CYCLES  = 250,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h1155,
    parameter logic [4*CODE_LEN-1:0] MASTER_CODE  = 16'h1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       door_closed,
    output logic [4:0] lights,
    output logic       alarm,
    output logic [3:0] entry_cnt
);

    localparam int W  = 4 * CODE_LEN;
    localparam int TW = (FAIL_CYCLES > 1) ? $clog2(FAIL_CYCLES) : 1;

    state_t         state, state_nxt;
    logic [W-1:0]   user_code, user_code_nxt;
    logic [3:0]     fail_cnt, fail_cnt_nxt, fail_inc;
    logic           stage, stage_nxt;
    logic [TW-1:0]  timer, timer_nxt;
    logic           door_d1, door_d2, door_rise;
    logic           key_dig, key_star, key_hash;
    logic           digit_take, buf_clear;
    logic [W-1:0]   entry_code;
    logic           entry_full;

    assign key_dig   = key_valid && is_digit(key_code);
    assign key_star  = key_valid && (key_code == KEY_STAR);
    assign key_hash  = key_valid && (key_code == KEY_HASH);
    assign door_rise = door_d1 && !door_d2;
    assign fail_inc  = fail_cnt + 4'd1;

    elock_entry #(
        .CODE_LEN (CODE_LEN)
    ) u_entry (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_take),
        .digit       (key_code),
        .clear       (buf_clear),
        .code        (entry_code),
        .entry_cnt   (entry_cnt),
        .full        (entry_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_UNARMED;
            user_code <= DEFAULT_CODE;
            fail_cnt  <= '0;
            stage     <= 1'b0;
            timer     <= '0;
            door_d1   <= 1'b0;
            door_d2   <= 1'b0;
            lights    <= LIGHTS_UNARMED;
            alarm     <= 1'b0;
        end else begin
            state     <= state_nxt;
            user_code <= user_code_nxt;
            fail_cnt  <= fail_cnt_nxt;
            stage     <= stage_nxt;
            timer     <= timer_nxt;
            door_d1   <= door_closed;
            door_d2   <= door_d1;
            lights    <= lights_of(state_nxt);
            alarm     <= (state_nxt == ST_ALARM) || (state_nxt == ST_ALARM_FAIL);
        end
    end

    always_comb begin
        state_nxt     = state;
        user_code_nxt = user_code;
        fail_cnt_nxt  = fail_cnt;
        stage_nxt     = stage;
        timer_nxt     = timer;
        digit_take    = 1'b0;
        buf_clear     = 1'b0;

        case (state)
            ST_UNARMED: begin
                if (key_hash) state_nxt = ST_LOCKED;
            end

            ST_LOCKED: begin
                digit_take = key_dig;
                buf_clear  = key_star;
                if (entry_full) begin
                    if (entry_code == user_code) begin
                        state_nxt    = ST_OPEN;
                        fail_cnt_nxt = '0;
                    end else if (fail_inc == 4'(MAX_FAIL)) begin
                        state_nxt    = ST_ALARM;
                        fail_cnt_nxt = '0;
                    end else begin
                        state_nxt    = ST_FAIL;
                        fail_cnt_nxt = fail_inc;
                        timer_nxt    = TW'(FAIL_CYCLES - 1);
                    end
                end
            end

            ST_FAIL: begin
                if (timer == '0) state_nxt = ST_LOCKED;
                else             timer_nxt = timer - TW'(1);
            end

            // Door edge wins over any key in the same cycle.
            ST_OPEN: begin
                if (door_rise) begin
                    state_nxt = ST_LOCKED;
                end else begin
                    digit_take = key_dig;
                    if (key_hash)
                        state_nxt = ST_LOCKED;
                    else if (key_star)
                        state_nxt = ST_UNARMED;
                    else if (entry_full && (entry_code == MASTER_CODE))
                        state_nxt = ST_PCHANGE;
                end
            end

            ST_PCHANGE: begin
                if (door_rise) begin
                    state_nxt = ST_LOCKED;
                end else begin
                    digit_take = key_dig;
                    if (key_star) begin
                        state_nxt = ST_OPEN;
                    end else if (entry_full) begin
                        user_code_nxt = entry_code;
                        state_nxt     = ST_OPEN;
                    end
                end
            end

            ST_ALARM: begin
                digit_take = key_dig;
                buf_clear  = key_star;
                if (entry_full) begin
                    if (!stage && (entry_code == user_code)) begin
                        stage_nxt = 1'b1;
                    end else if (stage && (entry_code == MASTER_CODE)) begin
                        stage_nxt = 1'b0;
                        state_nxt = ST_UNARMED;
                    end else begin
                        stage_nxt = 1'b0;
                        state_nxt = ST_ALARM_FAIL;
                        timer_nxt = TW'(FAIL_CYCLES - 1);
                    end
                end
            end

            ST_ALARM_FAIL: begin
                if (timer == '0) state_nxt = ST_ALARM;
                else             timer_nxt = timer - TW'(1);
            end

            default: state_nxt = ST_UNARMED;
        endcase
    end

endmodule

// File: tb/tb_elock_ctrl.sv
// Bench for elock_ctrl: a queue-based behavioural model checked every cycle,
// plus directed sequences with literal expectations on lights and entry_cnt.
module tb_elock_ctrl;

    localparam int          CODE_LEN    = 4;
    localparam int          MAX_FAIL    = 2;
    localparam int          FAIL_CYCLES = 250;
    localparam logic [15:0] DEF_CODE    = 16'h1155;
    localparam logic [15:0] MAS_CODE    = 16'h1111;

    localparam logic [4:0] L_UN = 5'b00000, L_LK = 5'b01100, L_OP = 5'b00101,
                           L_FL = 5'b01110, L_AL = 5'b11100, L_AF = 5'b11110,
                           L_PC = 5'b00111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       door_closed = 1'b0;
    logic [4:0] lights;
    logic       alarm;
    logic [3:0] entry_cnt;

    int vectors = 0;
    int miscompares = 0;

    elock_ctrl #(
        .CODE_LEN     (CODE_LEN),
        .MAX_FAIL     (MAX_FAIL),
        .FAIL_CYCLES  (FAIL_CYCLES),
        .DEFAULT_CODE (DEF_CODE),
        .MASTER_CODE  (MAS_CODE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .door_closed (door_closed),
        .lights      (lights),
        .alarm       (alarm),
        .entry_cnt   (entry_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    localparam int M_UN = 0, M_LK = 1, M_OP = 2, M_FL = 3, M_AL = 4, M_AF = 5, M_PC = 6;

    int          m_mode = M_UN;
    int          m_q[$];
    int          m_user = int'(DEF_CODE);
    int          m_fails = 0;
    int          m_stage = 0;
    int          m_rel = 0;
    int          m_cyc = 0;
    bit          m_d1 = 0, m_d2 = 0;

    function automatic logic [4:0] mode_lights(input int m);
        case (m)
            M_LK: return L_LK;
            M_OP: return L_OP;
            M_FL: return L_FL;
            M_AL: return L_AL;
            M_AF: return L_AF;
            M_PC: return L_PC;
            default: return L_UN;
        endcase
    endfunction

    task automatic model_step();
        bit door_rise, full, dig, star, hash, take, clr;
        int v;
        door_rise = m_d1 && !m_d2;
        full = (m_q.size() == CODE_LEN);
        v = 0;
        if (full) foreach (m_q[i]) v = v * 16 + m_q[i];
        dig  = key_valid && (key_code <= 4'd9);
        star = key_valid && (key_code == 4'hE);
        hash = key_valid && (key_code == 4'hF);
        take = 0;
        clr  = full;
        case (m_mode)
            M_UN: if (hash) m_mode = M_LK;
            M_LK: begin
                take = dig;
                if (star) clr = 1;
                if (full) begin
                    if (v == m_user) begin
                        m_mode = M_OP; m_fails = 0;
                    end else begin
                        m_fails++;
                        if (m_fails == MAX_FAIL) begin
                            m_mode = M_AL; m_fails = 0;
                        end else begin
                            m_mode = M_FL; m_rel = m_cyc + FAIL_CYCLES;
                        end
                    end
                end
            end
            M_FL: if (m_cyc == m_rel) m_mode = M_LK;
            M_OP: begin
                if (door_rise) m_mode = M_LK;
                else begin
                    take = dig;
                    if (hash) m_mode = M_LK;
                    else if (star) m_mode = M_UN;
                    else if (full && v == int'(MAS_CODE)) m_mode = M_PC;
                end
            end
            M_PC: begin
                if (door_rise) m_mode = M_LK;
                else begin
                    take = dig;
                    if (star) m_mode = M_OP;
                    else if (full) begin m_user = v; m_mode = M_OP; end
                end
            end
            M_AL: begin
                take = dig;
                if (star) clr = 1;
                if (full) begin
                    if (m_stage == 0 && v == m_user) m_stage = 1;
                    else if (m_stage == 1 && v == int'(MAS_CODE)) begin
                        m_stage = 0; m_mode = M_UN;
                    end else begin
                        m_stage = 0; m_mode = M_AF; m_rel = m_cyc + FAIL_CYCLES;
                    end
                end
            end
            M_AF: if (m_cyc == m_rel) m_mode = M_AL;
            default: m_mode = M_UN;
        endcase
        if (clr) m_q.delete();
        if (take) m_q.push_back(int'(key_code));
        m_d2 = m_d1;
        m_d1 = door_closed;
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_mode = M_UN; m_q.delete(); m_user = int'(DEF_CODE);
            m_fails = 0; m_stage = 0; m_d1 = 0; m_d2 = 0;
        end else begin
            model_step();
        end
        m_cyc++;
    end

    // Per-cycle compare against the model.
    initial forever begin
        logic [4:0] el;
        logic       ea;
        int         ec;
        @(negedge clk);
        el = mode_lights(m_mode);
        ea = (m_mode == M_AL) || (m_mode == M_AF);
        ec = m_q.size();
        vectors++;
        if (lights !== el || alarm !== ea || int'(entry_cnt) != ec) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL model t=%0t: lights=%b alarm=%b cnt=%0d, expected lights=%b alarm=%b cnt=%0d",
                         $time, lights, alarm, entry_cnt, el, ea, ec);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic lit(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic enter(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) press(code[4*i +: 4]);
    endtask

    task automatic count_while(input logic [4:0] want, output int n);
        n = 0;
        while (lights == want && n < 1000) begin idle(1); n++; end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1;
        lit("reset_lights", lights, L_UN);
        lit("reset_alarm", alarm, 0);
        lit("reset_cnt", entry_cnt, 0);
        rst = 1'b0;
        idle(1);

        press(4'hF);
        lit("hash_to_locked", lights, L_LK);
        enter(16'h1155);
        lit("cnt_full", entry_cnt, 4);
        lit("compare_cycle_still_locked", lights, L_LK);
        idle(1);
        lit("open_2_cycles", lights, L_OP);
        lit("cnt_cleared", entry_cnt, 0);

        press(4'hF);
        lit("open_hash_locked", lights, L_LK);
        enter(16'h1234); idle(1);
        lit("wrong_code_fail", lights, L_FL);
        count_while(L_FL, n);
        lit("fail_hold_cycles", n, FAIL_CYCLES);
        lit("fail_back_locked", lights, L_LK);
        enter(16'h9999); idle(1);
        lit("second_fail_alarm", lights, L_AL);
        lit("alarm_out", alarm, 1);

        enter(16'h1155); idle(2);
        lit("alarm_stage1_stays", lights, L_AL);
        enter(16'h1111); idle(1);
        lit("alarm_cleared", lights, L_UN);
        lit("alarm_out_cleared", alarm, 0);

        press(4'hF);
        enter(16'h9999); idle(1);
        count_while(L_FL, n);
        enter(16'h9999); idle(1);
        lit("alarm_again", lights, L_AL);
        enter(16'h1111); idle(1);
        lit("master_first_alarm_fail", lights, L_AF);
        count_while(L_AF, n);
        lit("alarm_fail_hold", n, FAIL_CYCLES);
        lit("alarm_fail_back", lights, L_AL);
        enter(16'h1155); idle(1);
        enter(16'h1111); idle(1);
        lit("alarm_cleared2", lights, L_UN);

        press(4'hF);
        enter(16'h1155); idle(1);
        lit("open_again", lights, L_OP);
        enter(16'h1111); idle(1);
        lit("master_pchange", lights, L_PC);
        enter(16'h4321); idle(1);
        lit("pchange_done", lights, L_OP);
        press(4'hF);
        enter(16'h4321); idle(1);
        lit("new_code_opens", lights, L_OP);
        press(4'hF);
        enter(16'h1155); idle(1);
        lit("old_code_fails", lights, L_FL);
        count_while(L_FL, n);

        press(4'h1); press(4'h2);
        lit("two_digits", entry_cnt, 2);
        press(4'hE);
        lit("star_clears", entry_cnt, 0);
        press(4'hA);
        lit("key_a_ignored", entry_cnt, 0);

        enter(16'h4321); idle(1);
        lit("open3", lights, L_OP);
        enter(16'h9999);
        press(4'h7);
        lit("key_in_compare_cycle", entry_cnt, 1);
        lit("discard_stays_open", lights, L_OP);
        press(4'h7); press(4'h7); press(4'h7); idle(1);
        lit("discard2_cnt", entry_cnt, 0);

        door_closed = 1'b1;
        idle(1);
        press(4'hE);
        lit("door_beats_star", lights, L_LK);
        idle(2);
        door_closed = 1'b0;
        idle(2);

        enter(16'h4321); idle(1);
        enter(16'h1111); idle(1);
        press(4'hE);
        lit("pchange_star_open", lights, L_OP);
        enter(16'h1111); idle(1);
        enter(16'h8765); idle(1);
        press(4'hF);
        enter(16'h8765); idle(1);
        lit("code_8765_opens", lights, L_OP);

        press(4'hF);
        press(4'h1); press(4'h2);
        lit("mid_entry_cnt", entry_cnt, 2);
        rst = 1'b1;
        #1;
        lit("rst_cnt", entry_cnt, 0);
        lit("rst_lights", lights, L_UN);
        idle(1);
        rst = 1'b0;
        idle(1);
        press(4'hF);
        enter(16'h1155); idle(1);
        lit("default_code_restored", lights, L_OP);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
